id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand forwarding and ALU-control decode, directly upstream of the ALU.
- Latches decoded ID-stage fields on each clock and decodes ALUOp/funct into the 3-bit ALU control code.
- Resolves rs1/rs2 hazards against the EX/MEM and MEM/WB stages, then drives the ALU's data1_i, data2_i and ALUCtrl_i.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- stall_i  in  1  hold all stage registers.
- flush_i  in  1  load a bubble.
- id_valid_i  in  1  ID slot holds a real instruction.
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices.
- id_alusrc_i  in  1  1 = operand B is the immediate.
- id_aluop_i  in  2  00 mem, 01 branch, 10 R-type, 11 I-type ALU.
- id_funct3_i  in  3  instruction funct3.
- id_funct7_i  in  7  instruction funct7.
- id_regwrite_i  in  1  instruction writes rd.
- exmem_regwrite_i, exmem_rd_i, exmem_data_i  in  1/REG_AW/XLEN  EX/MEM writeback info.
- memwb_regwrite_i, memwb_rd_i, memwb_data_i  in  1/REG_AW/XLEN  MEM/WB writeback info.
- data1_o, data2_o  out  XLEN  ALU operands.
- aluctrl_o  out  3  ALU control code.
- store_data_o  out  XLEN  forwarded rs2 value for stores.
- rd_o  out  REG_AW  registered rd.
- regwrite_o  out  1  registered regwrite, gated by valid.
- valid_o  out  1  EX slot valid.
- illegal_o  out  1  unsupported funct3 in the EX slot.

Behaviour:
- Reset (async, rst_n_i=0): all stage registers clear to 0. Outputs are then valid_o=0, regwrite_o=0, rd_o=0, aluctrl_o=000, illegal_o=0.
  - data1_o and data2_o follow the forwarding rules from the zeroed registers; with exmem/memwb regwrite low they are 0.
  - Reset deassertion takes effect at the next edge, with no partial state.
- Edge priority:
  1. flush_i: load a bubble (valid=0, regwrite=0, rd=0, rs1=rs2=0, other fields 0).
  2. else stall_i: hold every register.
  3. else capture all id_* inputs.
- Flush overrides stall in the same cycle.
- regwrite_o = reg_regwrite & reg_valid.
- Latency: ID inputs appear on the outputs one cycle after capture. Forwarding and decode are combinational from the registers plus the exmem/memwb inputs.
- Forwarding for A (rs1); B (rs2) uses identical rules:
  - Select EX/MEM if exmem_regwrite_i, exmem_rd_i != 0 and exmem_rd_i == reg_rs1.
  - Else select MEM/WB under the same conditions with the memwb_* inputs.
  - Else use the registered rs1 data.
  - EX/MEM wins when both stages match.
  - rd == 0 never forwards.
- Operand B:
  - fwdB is the forwarded rs2 value.
  - data2_o = reg_alusrc ? reg_imm : fwdB.
  - store_data_o = fwdB always.
  - data1_o = fwdA.
- ALU control encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 sra, 111 srl.
- Decode by ALUOp:
  - aluop 00 -> add.
  - aluop 01 -> sub.
  - aluop 10 / 11, by funct3:
    - 000 -> sub only when aluop=10 and funct7[5]=1, else add.
    - 111 -> and.
    - 110 -> or.
    - 100 -> xor.
    - 001 -> sll.
    - 101 -> sra if funct7[5]=1, else srl (applies to both 10 and 11).
    - 010 / 011 -> add with illegal_o=1.
- illegal_o is gated by reg_valid.
- Bubble: aluop=00 with zero operands gives add 0+0.
- Stall with changing exmem/memwb inputs: the forwarded outputs may change. The registers do not.

Decomposition:
- Shared package, also used by the ALU and its bench:
  - ALU control localparams (ALU_ADD..ALU_SRL).
  - ALUOp localparams (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I).
  - funct3 constants.
- One sub-module, alu_ctrl_decode: combinational aluop/funct3/funct7 -> aluctrl plus illegal.
- The forwarding mux stays inline, instantiated twice via a function.

Test Plan:
- Reset/capture: assert rst_n_i=0 mid-cycle -> valid_o=0 and regwrite_o=0 immediately. Release, then capture R-type add (rs1=1 data 5, rs2=2 data 7) -> next cycle data1=5, data2=7, aluctrl=000.
- Decode sweep: R-type funct3/funct7 {000/0x20, 101/0x20, 101/0x00, 111, 110, 100, 001} -> 001, 110, 111, 010, 011, 100, 101. I-type 000 with funct7=0x20 -> 000. funct3=010 -> 000 with illegal_o=1.
- Forwarding: reg_rs1=3 with exmem rd=3 data 0xAAAA0000 and memwb rd=3 data 0x5555 -> data1=0xAAAA0000. Same case with exmem_rd=0 -> 0x5555. memwb_regwrite=0 -> register value.
- ALUSrc: alusrc=1, imm=0xFFFFFFFC, rs2 forwarded 0x1234 -> data2=0xFFFFFFFC, store_data=0x1234.
- Stall/flush: stall two cycles with new ID inputs -> outputs unchanged. flush_i and stall_i together -> valid_o=0, regwrite_o=0 next cycle.
- ALU integration: drive the ALU from this stage with sub of equal forwarded operands (0x1357) -> ALU zero_o=1.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared ALU control / ALUOp / funct3 encodings for the ID/EX stage, the ALU and their benches.
package id_ex_stage_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRA = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7 to 3-bit ALU control decode.
// SLT/SLTU have no ALU support; they decode to add and raise illegal.
module alu_ctrl_decode
   import id_ex_stage_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [2:0] aluctrl_o,
   output logic       illegal_o
);

   always_comb begin
      aluctrl_o = ALU_ADD;
      illegal_o = 1'b0;
      unique case (aluop_i)
         ALUOP_MEM: aluctrl_o = ALU_ADD;
         ALUOP_BR:  aluctrl_o = ALU_SUB;
         default: begin
            unique case (funct3_i)
               F3_ADD:  aluctrl_o = (aluop_i == ALUOP_R && funct7_i[5]) ? ALU_SUB : ALU_ADD;
               F3_AND:  aluctrl_o = ALU_AND;
               F3_OR:   aluctrl_o = ALU_OR;
               F3_XOR:  aluctrl_o = ALU_XOR;
               F3_SLL:  aluctrl_o = ALU_SLL;
               F3_SR:   aluctrl_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
               default: illegal_o = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and ALU-control decode.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_alusrc_i,
   input  logic [1:0]        id_aluop_i,
   input  logic [2:0]        id_funct3_i,
   input  logic [6:0]        id_funct7_i,
   input  logic              id_regwrite_i,
   input  logic              exmem_regwrite_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [XLEN-1:0]   exmem_data_i,
   input  logic              memwb_regwrite_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic [XLEN-1:0]   memwb_data_i,
   output logic [XLEN-1:0]   data1_o,
   output logic [XLEN-1:0]   data2_o,
   output logic [2:0]        aluctrl_o,
   output logic [XLEN-1:0]   store_data_o,
   output logic [REG_AW-1:0] rd_o,
   output logic              regwrite_o,
   output logic              valid_o,
   illegal_o
);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      logic              alusrc;
      logic [1:0]        aluop;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
   } stage_t;

   stage_t stage_q, stage_d, stage_in;

   assign stage_in = '{valid: id_valid_i, regwrite: id_regwrite_i, rd: id_rd_i,
                       rs1: id_rs1_i, rs2: id_rs2_i, rs1_data: id_rs1_data_i,
                       rs2_data: id_rs2_data_i, imm: id_imm_i, alusrc: id_alusrc_i,
                       aluop: id_aluop_i, funct3: id_funct3_i, funct7: id_funct7_i};

   // Flush beats stall so a squashed instruction never survives a hold.
   always_comb begin
      stage_d = stage_in;
      if (flush_i)      stage_d = '0;
      else if (stall_i) stage_d = stage_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) stage_q <= '0;
      else          stage_q <= stage_d;
   end

   // Nearest producer wins; x0 is hardwired zero so it never forwards.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [XLEN-1:0]   rdata,
      input logic              em_we,
      input logic [REG_AW-1:0] em_rd,
      input logic [XLEN-1:0]   em_data,
      input logic              mw_we,
      input logic [REG_AW-1:0] mw_rd,
      input logic [XLEN-1:0]   mw_data
   );
      if (em_we && em_rd != '0 && em_rd == rs)      return em_data;
      else if (mw_we && mw_rd != '0 && mw_rd == rs) return mw_data;
      else                                          return rdata;
   endfunction

   logic [XLEN-1:0] fwd_a, fwd_b;
   logic            illegal_raw;

   assign fwd_a = fwd_sel(stage_q.rs1, stage_q.rs1_data, exmem_regwrite_i, exmem_rd_i,
                          exmem_data_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i);
   assign fwd_b = fwd_sel(stage_q.rs2, stage_q.rs2_data, exmem_regwrite_i, exmem_rd_i,
                          exmem_data_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i);

   alu_ctrl_decode u_alu_ctrl_decode (
      .aluop_i   (stage_q.aluop),
      .funct3_i  (stage_q.funct3),
      .funct7_i  (stage_q.funct7),
      .aluctrl_o (aluctrl_o),
      .illegal_o (illegal_raw)
   );

   assign data1_o      = fwd_a;
   assign data2_o      = stage_q.alusrc ? stage_q.imm : fwd_b;
   assign store_data_o = fwd_b;
   assign rd_o         = stage_q.rd;
   assign regwrite_o   = stage_q.regwrite & stage_q.valid;
   assign valid_o      = stage_q.valid;
   assign illegal_o    = illegal_raw & stage_q.valid;

endmodule
